// File: rtl/tag_array_ctrl.sv
// Tag-array controller: drives the tag SRAM wrapper, owns the per-line valid bits
// and serves lookup / fill / invalidate-line / invalidate-all requests.
module tag_array_ctrl #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 22,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic             tag_cs,
    output logic             tag_oe,
    output logic             tag_web,
    output logic [IDX_W-1:0] tag_a,
    output logic [TAG_W-1:0] tag_di,
    input  logic [TAG_W-1:0] tag_do,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    // state   | meaning
    // INIT    | post-reset scrub of every entry, requests blocked
    // IDLE    | ready; lookup read / fill write issued in the accept cycle
    // CMP     | SRAM read data valid, compare and respond
    // RESP    | one-cycle response for fill / invalidate ops
    // SWEEP   | invalidate-all scrub, then RESP
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_CMP   = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_SWEEP = 3'd4;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_INV    = 2'b10;
    localparam logic [1:0] OP_INVALL = 2'b11;

    logic [2:0]              state;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        idx_r;
    logic [TAG_W-1:0]        tag_r;
    logic [(1<<IDX_W)-1:0]   valid;
    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    hit;
    logic                    accept;
    logic                    unused_offset;

    assign req_tag       = req_addr[31 -: TAG_W];
    assign req_idx       = req_addr[4 +: IDX_W];
    assign unused_offset = ^req_addr[3:0];
    assign hit           = valid[idx_r] && (tag_do == tag_r);
    assign accept        = req_valid && req_ready;

    // Outputs are decoded from state; rst forces them idle so nothing leaks
    // out of an aborted operation during the reset cycle.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        tag_cs    = 1'b0;
        tag_oe    = 1'b0;
        tag_web   = 1'b1;
        tag_a     = '0;
        tag_di    = '0;
        if (!rst) begin
            case (state)
                S_INIT, S_SWEEP: begin
                    tag_cs  = 1'b1;
                    tag_web = 1'b0;
                    tag_a   = ptr;
                end
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (req_op == OP_LOOKUP) begin
                            tag_cs = 1'b1;
                            tag_oe = 1'b1;
                            tag_a  = req_idx;
                        end else if (req_op == OP_FILL) begin
                            tag_cs  = 1'b1;
                            tag_web = 1'b0;
                            tag_a   = req_idx;
                            tag_di  = req_tag;
                        end
                    end
                end
                S_CMP: begin
                    tag_oe    = 1'b1;
                    rsp_valid = 1'b1;
                    rsp_hit   = hit;
                end
                S_RESP: rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            ptr        <= '0;
            valid      <= '0;
            idx_r      <= '0;
            tag_r      <= '0;
            lookup_cnt <= '0;
            hit_cnt    <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    ptr <= ptr + IDX_W'(1);
                    if (ptr == '1) state <= S_IDLE;
                end
                S_SWEEP: begin
                    ptr <= ptr + IDX_W'(1);
                    if (ptr == '1) state <= S_RESP;
                end
                S_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_LOOKUP: begin
                                tag_r <= req_tag;
                                idx_r <= req_idx;
                                state <= S_CMP;
                            end
                            OP_FILL: begin
                                valid[req_idx] <= 1'b1;
                                state          <= S_RESP;
                            end
                            OP_INV: begin
                                valid[req_idx] <= 1'b0;
                                state          <= S_RESP;
                            end
                            default: begin
                                valid <= '0;
                                ptr   <= '0;
                                state <= S_SWEEP;
                            end
                        endcase
                    end
                end
                S_CMP: begin
                    // Counters saturate rather than wrap.
                    if (lookup_cnt != '1) lookup_cnt <= lookup_cnt + CNT_W'(1);
                    if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
                    state <= S_IDLE;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Self-checking bench for tag_array_ctrl with a behavioural tag SRAM and a
// response scoreboard (expected hit + latency queued at acceptance).
module tb_tag_array_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic        rsp_valid, rsp_hit;
    logic        tag_cs, tag_oe, tag_web;
    logic [5:0]  tag_a;
    logic [21:0] tag_di, tag_do;
    logic [31:0] lookup_cnt, hit_cnt;

    always #5 clk = ~clk;

    tag_array_ctrl #(.IDX_W(6), .TAG_W(22), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .tag_cs(tag_cs), .tag_oe(tag_oe), .tag_web(tag_web), .tag_a(tag_a),
        .tag_di(tag_di), .tag_do(tag_do),
        .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
    );

    // Behavioural SRAM: read data appears one cycle after the read.
    logic [21:0] mem [64];
    logic [21:0] dout;
    always @(posedge clk) begin
        if (tag_cs) begin
            if (!tag_web) mem[tag_a] <= tag_di;
            else if (tag_oe) dout <= mem[tag_a];
        end
    end
    assign tag_do = dout;

    typedef struct { bit hit; int lat; int acc; } exp_t;
    exp_t        expq[$];
    exp_t        e_mon;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_acc = 0;
    bit          prev_rsp = 1'b0;
    logic [5:0]  wr_a[$];
    logic [21:0] wr_d[$];
    bit          mv[64];
    logic [21:0] mt[64];
    int          exp_lk = 0;
    int          exp_ht = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tag_cs && !tag_web) begin
            wr_a.push_back(tag_a);
            wr_d.push_back(tag_di);
        end
        if (rsp_valid) begin
            n_checks++;
            if (prev_rsp) begin
                n_fail++;
                $display("FAIL rsp_back_to_back: rsp_valid high two cycles in a row at cycle %0d", cyc);
            end
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                e_mon = expq.pop_front();
                n_checks += 2;
                if (rsp_hit !== e_mon.hit) begin
                    n_fail++;
                    $display("FAIL rsp_hit: got %0b required %0b (cycle %0d)", rsp_hit, e_mon.hit, cyc);
                end
                if (cyc - e_mon.acc !== e_mon.lat) begin
                    n_fail++;
                    $display("FAIL rsp_latency: got %0d required %0d", cyc - e_mon.acc, e_mon.lat);
                end
            end
        end
        prev_rsp = rsp_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[9:4]] && (mt[a[9:4]] === a[31:10]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        exp_lk = 0;
        exp_ht = 0;
        expq.delete();
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input bit exp_hit);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: req_ready=0 after %0d cycles, required 1", n);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        e.hit = exp_hit;
        e.lat = (op == 2'b11) ? 65 : 1;
        e.acc = cyc;
        last_acc = cyc;
        expq.push_back(e);
        case (op)
            2'b00: begin exp_lk++; if (exp_hit) exp_ht++; end
            2'b01: begin mv[addr[9:4]] = 1'b1; mt[addr[9:4]] = addr[31:10]; end
            2'b10: mv[addr[9:4]] = 1'b0;
            default: for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        endcase
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: %0d responses outstanding, required 0", expq.size());
            expq.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic test_reset();
        int ready_at;
        int bad;
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({tag_cs, tag_oe, tag_web, tag_a, tag_di, rsp_valid, req_ready} !== {3'b001, 6'd0, 22'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: cs=%0b oe=%0b web=%0b a=%0d di=%0h rsp=%0b rdy=%0b, required 0 0 1 0 0 0 0",
                     tag_cs, tag_oe, tag_web, tag_a, tag_di, rsp_valid, req_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        wr_a.delete();
        wr_d.delete();
        ready_at = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ready_at = i;
                break;
            end
        end
        n_checks++;
        if (ready_at !== 65) begin
            n_fail++;
            $display("FAIL reset_ready_cycle: got %0d required 65", ready_at);
        end
        n_checks++;
        if (wr_a.size() !== 64) begin
            n_fail++;
            $display("FAIL reset_write_count: got %0d required 64", wr_a.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++) if (wr_a[i] !== 6'(i) || wr_d[i] !== 22'd0) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL reset_write_seq: %0d writes out of order or nonzero, required 0", bad);
            end
        end
        n_checks++;
        if (lookup_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", lookup_cnt, hit_cnt);
        end
    endtask

    task automatic test_fill_lookup();
        wr_a.delete();
        wr_d.delete();
        issue(2'b01, 32'h1234_5670, 1'b0);
        drain();
        n_checks++;
        if (wr_a.size() !== 1 || wr_a[0] !== 6'h27 || wr_d[0] !== 22'h048D15) begin
            n_fail++;
            $display("FAIL fill_write: got %0d writes a=%0h di=%0h, required 1 write a=27 di=048d15",
                     wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : 6'h0, (wr_d.size() > 0) ? wr_d[0] : 22'h0);
        end
        issue(2'b00, 32'h1234_5678, 1'b1);
        drain();
        n_checks++;
        if (lookup_cnt !== 32'd1 || hit_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL fill_lookup_counters: got %0d/%0d required 1/1", lookup_cnt, hit_cnt);
        end
    endtask

    task automatic test_mismatch();
        issue(2'b00, 32'h2234_5670, 1'b0);
        drain();
        n_checks++;
        if (lookup_cnt !== 32'd2 || hit_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL mismatch_counters: got %0d/%0d required 2/1", lookup_cnt, hit_cnt);
        end
    endtask

    task automatic test_inval_line();
        wr_a.delete();
        issue(2'b10, 32'h1234_5670, 1'b0);
        drain();
        n_checks++;
        if (wr_a.size() !== 0) begin
            n_fail++;
            $display("FAIL inval_no_write: got %0d SRAM writes required 0", wr_a.size());
        end
        issue(2'b00, 32'h1234_5670, 1'b0);
        drain();
    endtask

    task automatic test_inval_all();
        int bad;
        issue(2'b01, 32'h0000_0000, 1'b0);
        issue(2'b01, 32'hABCD_E3F0, 1'b0);
        issue(2'b00, 32'h0000_0004, 1'b1);
        issue(2'b00, 32'hABCD_E3FC, 1'b1);
        drain();
        wr_a.delete();
        wr_d.delete();
        issue(2'b11, 32'h5555_5555, 1'b0);
        drain();
        bad = 0;
        for (int i = 0; i < wr_a.size(); i++) if (wr_a[i] !== 6'(i) || wr_d[i] !== 22'd0) bad++;
        n_checks++;
        if (wr_a.size() !== 64 || bad != 0) begin
            n_fail++;
            $display("FAIL scrub_writes: got %0d writes (%0d bad) required 64 sequential zero writes", wr_a.size(), bad);
        end
        issue(2'b00, 32'h0000_0000, 1'b0);
        issue(2'b00, 32'hABCD_E3F0, 1'b0);
        drain();
        n_checks++;
        if (lookup_cnt !== 32'(exp_lk) || hit_cnt !== 32'(exp_ht)) begin
            n_fail++;
            $display("FAIL inval_all_counters: got %0d/%0d required %0d/%0d", lookup_cnt, hit_cnt, exp_lk, exp_ht);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int t0;
        a = $urandom;
        issue(2'b01, a, 1'b0);
        t0 = last_acc;
        for (int i = 0; i < 6; i++) begin
            issue(2'b00, a, model_hit(a));
            issue(2'b00, a ^ 32'h8000_0400, model_hit(a ^ 32'h8000_0400));
            a = $urandom;
            issue(2'b01, a, 1'b0);
        end
        n_checks++;
        if (last_acc - t0 !== 36) begin
            n_fail++;
            $display("FAIL throughput: 18 accepts spanned %0d cycles, required 36", last_acc - t0);
        end
        drain();
        n_checks++;
        if (lookup_cnt !== 32'(exp_lk) || hit_cnt !== 32'(exp_ht)) begin
            n_fail++;
            $display("FAIL b2b_counters: got %0d/%0d required %0d/%0d", lookup_cnt, hit_cnt, exp_lk, exp_ht);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        n = 0;
        @(negedge clk);
        while (!(tag_cs && tag_a == 6'd20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wr_a.delete();
        wait_ready();
        n_checks++;
        if (wr_a.size() !== 64 || wr_a[0] !== 6'd0 || wr_a[63] !== 6'd63) begin
            n_fail++;
            $display("FAIL mid_sweep_restart: got %0d writes first=%0d, required 64 writes from 0 to 63",
                     wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : 6'h3f);
        end
    endtask

    task automatic test_reset_mid_cmp();
        issue(2'b01, 32'h1234_5670, 1'b0);
        drain();
        wait_ready();
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_cmp_rsp: got rsp_valid=%0b required 0", rsp_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        wait_ready();
        n_checks++;
        if (lookup_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_cmp_counters: got %0d/%0d required 0/0", lookup_cnt, hit_cnt);
        end
        issue(2'b00, 32'h1234_5678, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_fill_lookup();
        test_mismatch();
        test_inval_line();
        test_inval_all();
        test_back_to_back();
        test_reset_mid_sweep();
        test_reset_mid_cmp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
